div_unit: RTL

- Iterative radix-2 restoring divider for the RV32 M extension (DIV, DIVU, REM, REMU); sits in the EX stage beside the ALU.
- Takes rs1/rs2 and funct3 from the ID/EX register and returns one 32-bit result to the EX/MEM path.
- Uses a valid/ready handshake on both sides so the hazard unit can stall the pipe while a division is running.

---
 rtl/div_unit_pkg.sv | 21 ++
 rtl/div_unit_step.sv | 32 +++
 rtl/div_unit.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/div_unit_pkg.sv
// Shared definitions for the RV32 M-extension divider: operand width, funct3 codes,
// divider FSM states and the architectural results for the special cases.
package div_unit_pkg;

   localparam int XLEN = 32;

   typedef logic [XLEN-1:0] data_t;
   typedef logic [2:0]      funct3_t;

   localparam funct3_t F3_DIV  = 3'b100;
   localparam funct3_t F3_DIVU = 3'b101;
   localparam funct3_t F3_REM  = 3'b110;
   localparam funct3_t F3_REMU = 3'b111;

   typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} div_state_t;

   localparam int    DIV_ITER      = XLEN;
   localparam data_t DIV_BY_ZERO_Q = 32'hFFFF_FFFF;
   localparam data_t DIV_OVF_Q     = 32'h8000_0000;

endpackage

// File: rtl/div_unit_step.sv
// One restoring-division step: shift {rem, quo} left, trial-subtract the divisor,
// keep the difference and set the quotient bit when it does not go negative.
module div_unit_step
   import div_unit_pkg::*;
(
   input  logic [XLEN:0]   rem,
   input  logic [XLEN-1:0] quo,
   input  logic [XLEN-1:0] divisor,
   output logic [XLEN:0]   rem_nxt,
   output logic [XLEN-1:0] quo_nxt
);

   logic [XLEN:0] shifted;
   logic [XLEN:0] trial;
   logic          unused_rem_msb;

   // The partial remainder is always below the divisor, so its top bit is never set here.
   assign unused_rem_msb = rem[XLEN];

   always_comb begin
      shifted = {rem[XLEN-1:0], quo[XLEN-1]};
      trial   = shifted - {1'b0, divisor};
      if (!trial[XLEN]) begin
         rem_nxt = trial;
         quo_nxt = {quo[XLEN-2:0], 1'b1};
      end else begin
         rem_nxt = shifted;
         quo_nxt = {quo[XLEN-2:0], 1'b0};
      end
   end

endmodule

// File: rtl/div_unit.sv
// Iterative radix-2 restoring divider for DIV/DIVU/REM/REMU with valid/ready on both sides.
// Optional build macro DIV_EARLY_OUT_EN: finish in one edge when |rs1| < |rs2|.
module div_unit
   import div_unit_pkg::*;
#(
   parameter int ITER = DIV_ITER
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            flush,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [2:0]      funct3,
   input  logic [XLEN-1:0] rs1,
   input  logic [XLEN-1:0] rs2,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] result
);

   localparam int CW = $clog2(ITER);

   div_state_t      state_q, state_d;
   logic [CW-1:0]   count_q, count_d;
   logic [XLEN:0]   rem_q, rem_d;
   logic [XLEN-1:0] quo_q, quo_d;
   logic [XLEN-1:0] dvs_q, dvs_d;
   logic [XLEN-1:0] result_q, result_d;
   logic [1:0]      op_q, op_d;
   logic            qneg_q, qneg_d;
   logic            rneg_q, rneg_d;
   logic            out_valid_q, out_valid_d;
   logic            in_ready_q, in_ready_d;

   logic signed [XLEN-1:0] rs1_s, rs2_s;
   logic [XLEN-1:0] abs1, abs2;
   logic [XLEN:0]   step_rem;
   logic [XLEN-1:0] step_quo;
   logic            is_signed, accept, div_zero, overflow, early;
   logic            unused_f3;

   function automatic logic [XLEN-1:0] cond_neg(input logic [XLEN-1:0] v, input logic neg);
      return neg ? (~v + 1'b1) : v;
   endfunction

   assign unused_f3 = funct3[2];
   assign is_signed = ~funct3[0];
   assign rs1_s     = rs1;
   assign rs2_s     = rs2;
   assign abs1      = cond_neg(rs1, is_signed & (rs1_s < 0));
   assign abs2      = cond_neg(rs2, is_signed & (rs2_s < 0));
   assign div_zero  = (rs2 == '0);
   assign overflow  = is_signed & (rs1 == DIV_OVF_Q) & (rs2 == DIV_BY_ZERO_Q);
`ifdef DIV_EARLY_OUT_EN
   assign early     = (abs1 < abs2);
`else
   assign early     = 1'b0;
`endif
   assign accept    = in_valid & in_ready_q & ~flush;

   div_unit_step u_step (
      .rem     (rem_q),
      .quo     (quo_q),
      .divisor (dvs_q),
      .rem_nxt (step_rem),
      .quo_nxt (step_quo)
   );

   always_comb begin
      state_d     = state_q;
      count_d     = count_q;
      rem_d       = rem_q;
      quo_d       = quo_q;
      dvs_d       = dvs_q;
      result_d    = result_q;
      op_d        = op_q;
      qneg_d      = qneg_q;
      rneg_d      = rneg_q;
      out_valid_d = out_valid_q;
      in_ready_d  = in_ready_q;

      if (flush) begin
         state_d     = IDLE;
         out_valid_d = 1'b0;
         in_ready_d  = 1'b1;
      end else begin
         case (state_q)
            IDLE: begin
               if (accept) begin
                  op_d       = funct3[1:0];
                  qneg_d     = rs1[XLEN-1] ^ rs2[XLEN-1];
                  rneg_d     = rs1[XLEN-1];
                  rem_d      = '0;
                  quo_d      = abs1;
                  dvs_d      = abs2;
                  in_ready_d = 1'b0;
                  // Special cases bypass the iteration and land directly in DONE.
                  if (div_zero || overflow || early) begin
                     if (div_zero)      result_d = funct3[1] ? rs1 : DIV_BY_ZERO_Q;
                     else if (overflow) result_d = funct3[1] ? '0  : DIV_OVF_Q;
                     else               result_d = funct3[1] ? rs1 : '0;
                     state_d     = DONE;
                     out_valid_d = 1'b1;
                  end else begin
                     state_d = CALC;
                     count_d = CW'(ITER - 1);
                  end
               end
            end
            CALC: begin
               rem_d = step_rem;
               quo_d = step_quo;
               if (count_q == '0) state_d = FIX;
               else               count_d = count_q - 1'b1;
            end
            FIX: begin
               result_d    = op_q[1] ? cond_neg(rem_q[XLEN-1:0], ~op_q[0] & rneg_q)
                                     : cond_neg(quo_q, ~op_q[0] & qneg_q);
               state_d     = DONE;
               out_valid_d = 1'b1;
            end
            DONE: begin
               if (out_ready) begin
                  state_d     = IDLE;
                  out_valid_d = 1'b0;
                  in_ready_d  = 1'b1;
               end
            end
            default: begin
               state_d     = IDLE;
               out_valid_d = 1'b0;
               in_ready_d  = 1'b1;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         count_q     <= '0;
         rem_q       <= '0;
         quo_q       <= '0;
         dvs_q       <= '0;
         result_q    <= '0;
         op_q        <= '0;
         qneg_q      <= 1'b0;
         rneg_q      <= 1'b0;
         out_valid_q <= 1'b0;
         in_ready_q  <= 1'b1;
      end else begin
         state_q     <= state_d;
         count_q     <= count_d;
         rem_q       <= rem_d;
         quo_q       <= quo_d;
         dvs_q       <= dvs_d;
         result_q    <= result_d;
         op_q        <= op_d;
         qneg_q      <= qneg_d;
         rneg_q      <= rneg_d;
         out_valid_q <= out_valid_d;
         in_ready_q  <= in_ready_d;
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign result    = result_q;

endmodule
